// File: rtl/flash_seq_pkg.sv
// Shared types and LED patterns for the flash sequencer.
package flash_seq_pkg;

  localparam int unsigned LED_W  = 16;
  localparam int unsigned FCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [LED_W-1:0] WIN_PAT    = 16'hFFFF;
  localparam logic [LED_W-1:0] LOSE_PAT_A = 16'hAAAA;
  localparam logic [LED_W-1:0] LOSE_PAT_B = 16'h5555;
  localparam logic [LED_W-1:0] IDLE_PAT   = 16'h0000;

  // Pattern shown during ON phase number `phase` (1-based).
  function automatic logic [LED_W-1:0] phase_pat(input logic win, input logic alt_en,
                                                 input logic [FCNT_W-1:0] phase);
    if (win) return WIN_PAT;
    if (alt_en && !phase[0]) return LOSE_PAT_B;
    return LOSE_PAT_A;
  endfunction

endpackage

// File: rtl/flash_sequencer_phase_timer.sv
// Loadable down-counter timing one ON or OFF phase; stops at zero.
module phase_timer #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/flash_sequencer.sv
// Win/lose LED blink sequencer feeding the LED output mux.
// Optional: define FLASH_SEQ_LOSE_ALT_EN to alternate the lose pattern per ON phase.
module flash_sequencer
  import flash_seq_pkg::*;
#(
  parameter int unsigned HALF_PERIOD_CYC = 25_000_000,
  parameter int unsigned NUM_FLASHES     = 3,
  parameter int unsigned CNT_W           = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_win,
  input  logic             start_lose,
  input  logic             abort,
  output logic             flash,
  output logic [LED_W-1:0] l2,
  output logic             busy,
  output logic             done,
  output logic             result
);

`ifdef FLASH_SEQ_LOSE_ALT_EN
  localparam logic LOSE_ALT = 1'b1;
`else
  localparam logic LOSE_ALT = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [FCNT_W-1:0] flash_cnt, flash_cnt_nxt;
  logic [LED_W-1:0]  l2_nxt;
  logic              flash_nxt, busy_nxt, done_nxt, result_nxt;
  logic              start_c, running_c, tmr_load_c, expired;

  assign start_c    = start_win | start_lose;
  assign running_c  = (state == ON) || (state == OFF);
  assign tmr_load_c = ((state == IDLE) && start_c) || (running_c && expired && !abort);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .en       (running_c),
    .load_val (CNT_W'(HALF_PERIOD_CYC - 1)),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Abort takes priority over phase expiry while running.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_c) state_nxt = ON;
      ON: begin
        if (abort)        state_nxt = IDLE;
        else if (expired) state_nxt = OFF;
      end
      OFF: begin
        if (abort)        state_nxt = IDLE;
        else if (expired) state_nxt = (flash_cnt == FCNT_W'(NUM_FLASHES)) ? DONE : ON;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the state being entered.
  always_comb begin
    flash_nxt     = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    result_nxt    = result;
    l2_nxt        = l2;
    flash_cnt_nxt = flash_cnt;
    unique case (state_nxt)
      IDLE: l2_nxt = IDLE_PAT;
      ON: begin
        flash_nxt = 1'b1;
        busy_nxt  = 1'b1;
        if (state == IDLE) begin
          result_nxt    = start_win & ~start_lose;
          flash_cnt_nxt = FCNT_W'(1);
          l2_nxt        = phase_pat(result_nxt, LOSE_ALT, FCNT_W'(1));
        end else if (state == OFF) begin
          flash_cnt_nxt = flash_cnt + FCNT_W'(1);
          l2_nxt        = phase_pat(result, LOSE_ALT, flash_cnt_nxt);
        end
      end
      OFF:  busy_nxt = 1'b1;
      DONE: done_nxt = 1'b1;
      default: l2_nxt = IDLE_PAT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 1'b0;
      l2        <= IDLE_PAT;
      flash_cnt <= '0;
    end else begin
      flash     <= flash_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      result    <= result_nxt;
      l2        <= l2_nxt;
      flash_cnt <= flash_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_flash_sequencer.sv
// Randomized self-checking bench for flash_sequencer against a cycle-offset reference model.
module tb_flash_sequencer;

  localparam int H   = 4;
  localparam int N   = 3;
  localparam int SEQ = 2 * N * H;

`ifdef FLASH_SEQ_LOSE_ALT_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_win = 1'b0, start_lose = 1'b0, abort = 1'b0;
  logic        flash, busy, done, result;
  logic [15:0] l2;

  logic        s1_win = 1'b0;
  logic        flash1, busy1, done1, result1;
  logic [15:0] l2_1;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_t = edges since the accepting edge (0 = idle), m_res = latched outcome.
  int   m_t   = 0;
  logic m_res = 1'b0;

  always #5 clk = ~clk;

  flash_sequencer #(.HALF_PERIOD_CYC(H), .NUM_FLASHES(N), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .start_win(start_win), .start_lose(start_lose), .abort(abort),
    .flash(flash), .l2(l2), .busy(busy), .done(done), .result(result)
  );

  flash_sequencer #(.HALF_PERIOD_CYC(1), .NUM_FLASHES(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start_win(s1_win), .start_lose(1'b0), .abort(1'b0),
    .flash(flash1), .l2(l2_1), .busy(busy1), .done(done1), .result(result1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_l2();
    int p, k;
    if (m_t == 0) return 16'h0000;
    p = ((m_t > SEQ) ? SEQ : m_t) - 1;
    k = (p / H) / 2 + 1;
    if (m_res) return 16'hFFFF;
    if (ALT && (k % 2 == 0)) return 16'h5555;
    return 16'hAAAA;
  endfunction

  task automatic compare_outputs();
    logic on_seq;
    on_seq = (m_t >= 1) && (m_t <= SEQ);
    check("flash",  32'(flash),  32'(on_seq && (((m_t - 1) / H) % 2 == 0)));
    check("busy",   32'(busy),   32'(on_seq));
    check("done",   32'(done),   32'(m_t == SEQ + 1));
    check("result", 32'(result), 32'(m_res));
    check("l2",     32'(l2),     32'(exp_l2()));
  endtask

  task automatic model_edge(input logic sw, input logic sl, input logic ab);
    if (m_t == 0) begin
      if (sw || sl) begin
        m_t   = 1;
        m_res = sw & ~sl;
      end
    end else if (m_t <= SEQ) begin
      m_t = ab ? 0 : m_t + 1;
    end else begin
      m_t = 0;
    end
  endtask

  // Check current outputs, then apply inputs for one clock edge.
  task automatic drive_cycle(input logic sw, input logic sl, input logic ab);
    @(negedge clk);
    compare_outputs();
    start_win  = sw;
    start_lose = sl;
    abort      = ab;
    @(posedge clk);
    model_edge(sw, sl, ab);
  endtask

  initial begin
    #12;
    compare_outputs();
    check("rst_flash1", 32'(flash1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Win sequence, then combined win+lose.
    for (int c = 0; c < 28; c++) drive_cycle(c == 0, 1'b0, 1'b0);
    for (int c = 0; c < 28; c++) drive_cycle(c == 0, c == 0, 1'b0);
    // Late start_win during a lose sequence is ignored.
    for (int c = 0; c < 28; c++) drive_cycle(c == 6, c == 0, 1'b0);
    // Abort in ON phase 2, restart two cycles later.
    for (int c = 0; c < 40; c++) drive_cycle(c == 0 || c == 12, 1'b0, c == 10);
    // Start during DONE->IDLE edge is dropped; abort+start in IDLE accepted.
    for (int c = 0; c < 30; c++) drive_cycle(c == 0 || c == 25, 1'b0, 1'b0);
    for (int c = 0; c < 30; c++) drive_cycle(1'b0, c == 0, c == 0);

    // Asynchronous reset in the middle of an ON phase.
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    m_t   = 0;
    m_res = 1'b0;
    compare_outputs();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 28; c++) drive_cycle(c == 0, 1'b0, 1'b0);

    // Random traffic.
    for (int c = 0; c < 2000; c++)
      drive_cycle($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 3);
    drive_cycle(1'b0, 1'b0, 1'b0);

    // Minimal configuration: one flash of one cycle.
    @(negedge clk);
    s1_win = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1 s1_win = 1'b0;
      check("min_flash",  32'(flash1),  32'(c == 1));
      check("min_busy",   32'(busy1),   32'(c <= 2));
      check("min_done",   32'(done1),   32'(c == 3));
      check("min_l2",     32'(l2_1),    (c <= 3) ? 32'h0000FFFF : 32'h0);
      check("min_result", 32'(result1), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
